sram_bist_initiator: RTL and testbench

RTAP-side master for the SRAM debug (BIST) nibble bus. It accepts one read or write request at a time, naming an SRAM ID, chunk ID and 16-bit address. It serializes the request as the command/nibble sequence that every `sp_ram` BIST slave decodes, and for reads reassembles the 384-bit response from `srams_rtap_data`. It sits between the JTAG/RTAP register file and the broadcast `rtap_srams_*` bus.

---
 rtl/sram_bist_initiator.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_sram_bist_initiator.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bist_initiator.sv
// sram_bist_initiator
// RTAP-side master for the SRAM BIST nibble bus. Accepts one read or write
// request at a time and serialises it as ID / BSEL / ADDRESS shifts followed
// by either READ + 96 data-shift beats (read) or 80 data-shift beats (write),
// then two guard NOP cycles. Read nibbles are reassembled MSB-nibble first.
// Optional feature macro: BIST_INITIATOR_ABORT_EN (adds abort / rsp_aborted).
module sram_bist_initiator #(
    parameter int RSP_LATENCY = 0,
    localparam int JTAG_DATA_REQ_WIDTH    = 320,
    localparam int JTAG_DATA_RES_WIDTH    = 384,
    localparam int SRAM_WRAPPER_BUS_WIDTH = 4,
    localparam int BIST_OP_WIDTH          = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [7:0]                        req_sram_id,
    input  logic [7:0]                        req_chunk_id,
    input  logic [15:0]                       req_addr,
    input  logic [JTAG_DATA_REQ_WIDTH-1:0]    req_wdata,
    output logic                              rsp_valid,
    output logic                              rsp_write,
    output logic [JTAG_DATA_RES_WIDTH-1:0]    rsp_rdata,
    output logic                              busy,
    output logic [BIST_OP_WIDTH-1:0]          rtap_srams_bist_command,
    output logic [SRAM_WRAPPER_BUS_WIDTH-1:0] rtap_srams_bist_data,
    input  logic [SRAM_WRAPPER_BUS_WIDTH-1:0] srams_rtap_data
`ifdef BIST_INITIATOR_ABORT_EN
    ,
    input  logic                              abort,
    output logic                              rsp_aborted
`endif
);

    // Bus command encoding shared with the sp_ram BIST slaves.
    localparam logic [BIST_OP_WIDTH-1:0] OP_NOP        = 3'd0;
    localparam logic [BIST_OP_WIDTH-1:0] OP_SHIFT_ID   = 3'd1;
    localparam logic [BIST_OP_WIDTH-1:0] OP_SHIFT_BSEL = 3'd2;
    localparam logic [BIST_OP_WIDTH-1:0] OP_SHIFT_ADDR = 3'd3;
    localparam logic [BIST_OP_WIDTH-1:0] OP_READ       = 3'd4;
    localparam logic [BIST_OP_WIDTH-1:0] OP_SHIFT_DATA = 3'd5;

    // Beat counts of each phase, expressed as the last counter value.
    localparam logic [6:0] ID_LAST    = 7'd1;
    localparam logic [6:0] BSEL_LAST  = 7'd1;
    localparam logic [6:0] ADDR_LAST  = 7'd3;
    localparam logic [6:0] RDATA_LAST = 7'd95;
    localparam logic [6:0] WDATA_LAST = 7'd79;
    localparam logic [6:0] GUARD_LAST = 7'd1;

    // Last RDATA beat before the first returned nibble is valid (unused when
    // there is no return latency) and last DRAIN beat.
    localparam logic [6:0] LAT_LAST   = 7'(RSP_LATENCY) - 7'd1;
    localparam logic [2:0] DRAIN_LAST = 3'(RSP_LATENCY) - 3'd1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_BSEL,
        S_ADDR,
        S_OP,
        S_GAP,
        S_RDATA,
        S_WDATA,
        S_DRAIN,
        S_GUARD
    } state_t;

    state_t                           state;
    logic [6:0]                       beat_cnt;
    logic [2:0]                       drain_cnt;
    logic                             wr_q;
    logic                             cap_on;
    logic [6:0]                       cap_idx;
    logic                             cap_en;
    logic                             accept;
    logic                             wsr_shift;
    logic [31:0]                      hdr;
    logic [JTAG_DATA_REQ_WIDTH-1:0]   wsr;
    logic [JTAG_DATA_RES_WIDTH-1:0]   rd_buf;
    logic [JTAG_DATA_RES_WIDTH-1:0]   rd_next;
`ifdef BIST_INITIATOR_ABORT_EN
    logic                             abort_hit;
`endif

    assign req_ready = (state == S_IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid && (state == S_IDLE);

    // The write shift register advances once per emitted data nibble,
    // starting on the edge that launches the first WDATA beat.
    assign wsr_shift = ((state == S_ADDR) && (beat_cnt == ADDR_LAST)) ||
                       (state == S_WDATA);

    // Returned nibbles are captured once the return-path latency has elapsed,
    // which spills over into the DRAIN cycles.
    assign cap_en = cap_on && ((state == S_RDATA) || (state == S_DRAIN));

`ifdef BIST_INITIATOR_ABORT_EN
    // Abort is honoured only before the final WDATA beat and never during
    // the read data phase, so a committed write or a started shift-out is
    // always completed.
    assign abort_hit = abort &&
                       ((state == S_ID) || (state == S_BSEL) ||
                        (state == S_ADDR) || (state == S_OP) ||
                        (state == S_GAP) ||
                        ((state == S_WDATA) && (beat_cnt != WDATA_LAST)));
`endif

    // Insert the sampled nibble k at bit 383-4k so nibble 0 lands in the MSBs.
    always_comb begin
        rd_next = rd_buf;
        if (cap_en) begin
            rd_next[10'd383 - {1'b0, cap_idx, 2'b00} -: 4] = srams_rtap_data;
        end
    end

    // Request payload latches and shift registers (no reset needed).
    always_ff @(posedge clk) begin
        if (accept) begin
            hdr <= {req_sram_id[3:0], req_chunk_id, req_addr, 4'h0};
            wsr <= req_wdata;
        end else begin
            hdr <= {hdr[27:0], 4'h0};
            if (wsr_shift) begin
                wsr <= {wsr[JTAG_DATA_REQ_WIDTH-5:0], 4'h0};
            end
        end
        rd_buf <= rd_next;
    end

    // Sequencer: state, counters and all registered bus/response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= S_IDLE;
            beat_cnt                <= '0;
            drain_cnt               <= '0;
            wr_q                    <= 1'b0;
            cap_on                  <= 1'b0;
            cap_idx                 <= '0;
            rtap_srams_bist_command <= OP_NOP;
            rtap_srams_bist_data    <= '0;
            rsp_valid               <= 1'b0;
            rsp_write               <= 1'b0;
            rsp_rdata               <= '0;
`ifdef BIST_INITIATOR_ABORT_EN
            rsp_aborted             <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            if (cap_en) begin
                cap_idx <= cap_idx + 7'd1;
            end
`ifdef BIST_INITIATOR_ABORT_EN
            if (abort_hit) begin
                state                   <= S_GUARD;
                beat_cnt                <= '0;
                drain_cnt               <= '0;
                rtap_srams_bist_command <= OP_NOP;
                rtap_srams_bist_data    <= '0;
                rsp_valid               <= 1'b1;
                rsp_write               <= wr_q;
                rsp_aborted             <= 1'b1;
            end else begin
`endif
            case (state)
                S_IDLE: begin
                    rtap_srams_bist_command <= OP_NOP;
                    rtap_srams_bist_data    <= '0;
                    cap_on                  <= 1'b0;
                    if (req_valid) begin
                        state                   <= S_ID;
                        beat_cnt                <= '0;
                        drain_cnt               <= '0;
                        wr_q                    <= req_write;
                        rtap_srams_bist_command <= OP_SHIFT_ID;
                        rtap_srams_bist_data    <= req_sram_id[7:4];
                    end
                end
                S_ID: begin
                    rtap_srams_bist_data <= hdr[31:28];
                    if (beat_cnt == ID_LAST) begin
                        state                   <= S_BSEL;
                        beat_cnt                <= '0;
                        rtap_srams_bist_command <= OP_SHIFT_BSEL;
                    end else begin
                        beat_cnt <= beat_cnt + 7'd1;
                    end
                end
                S_BSEL: begin
                    rtap_srams_bist_data <= hdr[31:28];
                    if (beat_cnt == BSEL_LAST) begin
                        state                   <= S_ADDR;
                        beat_cnt                <= '0;
                        rtap_srams_bist_command <= OP_SHIFT_ADDR;
                    end else begin
                        beat_cnt <= beat_cnt + 7'd1;
                    end
                end
                S_ADDR: begin
                    if (beat_cnt == ADDR_LAST) begin
                        beat_cnt <= '0;
                        if (wr_q) begin
                            state                   <= S_WDATA;
                            rtap_srams_bist_command <= OP_SHIFT_DATA;
                            rtap_srams_bist_data    <= wsr[JTAG_DATA_REQ_WIDTH-1 -: 4];
                        end else begin
                            state                   <= S_OP;
                            rtap_srams_bist_command <= OP_READ;
                            rtap_srams_bist_data    <= '0;
                        end
                    end else begin
                        beat_cnt             <= beat_cnt + 7'd1;
                        rtap_srams_bist_data <= hdr[31:28];
                    end
                end
                S_OP: begin
                    state                   <= S_GAP;
                    beat_cnt                <= '0;
                    rtap_srams_bist_command <= OP_NOP;
                    rtap_srams_bist_data    <= '0;
                end
                S_GAP: begin
                    state                   <= S_RDATA;
                    beat_cnt                <= '0;
                    cap_on                  <= (RSP_LATENCY == 0);
                    cap_idx                 <= '0;
                    rtap_srams_bist_command <= OP_SHIFT_DATA;
                    rtap_srams_bist_data    <= '0;
                end
                S_RDATA: begin
                    rtap_srams_bist_data <= '0;
                    if (beat_cnt == LAT_LAST) begin
                        cap_on <= 1'b1;
                    end
                    if (beat_cnt == RDATA_LAST) begin
                        beat_cnt                <= '0;
                        rtap_srams_bist_command <= OP_NOP;
                        if (RSP_LATENCY == 0) begin
                            state     <= S_GUARD;
                            rsp_valid <= 1'b1;
                            rsp_write <= wr_q;
                            rsp_rdata <= rd_next;
`ifdef BIST_INITIATOR_ABORT_EN
                            rsp_aborted <= 1'b0;
`endif
                        end else begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 7'd1;
                    end
                end
                S_DRAIN: begin
                    rtap_srams_bist_command <= OP_NOP;
                    rtap_srams_bist_data    <= '0;
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= S_GUARD;
                        drain_cnt <= '0;
                        beat_cnt  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_write <= wr_q;
                        rsp_rdata <= rd_next;
`ifdef BIST_INITIATOR_ABORT_EN
                        rsp_aborted <= 1'b0;
`endif
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                S_WDATA: begin
                    if (beat_cnt == WDATA_LAST) begin
                        state                   <= S_GUARD;
                        beat_cnt                <= '0;
                        rtap_srams_bist_command <= OP_NOP;
                        rtap_srams_bist_data    <= '0;
                        rsp_valid               <= 1'b1;
                        rsp_write               <= wr_q;
`ifdef BIST_INITIATOR_ABORT_EN
                        rsp_aborted             <= 1'b0;
`endif
                    end else begin
                        beat_cnt             <= beat_cnt + 7'd1;
                        rtap_srams_bist_data <= wsr[JTAG_DATA_REQ_WIDTH-1 -: 4];
                    end
                end
                S_GUARD: begin
                    rtap_srams_bist_command <= OP_NOP;
                    rtap_srams_bist_data    <= '0;
                    if (beat_cnt == GUARD_LAST) begin
                        state    <= S_IDLE;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 7'd1;
                    end
                end
                default: begin
                    state                   <= S_IDLE;
                    beat_cnt                <= '0;
                    drain_cnt               <= '0;
                    rtap_srams_bist_command <= OP_NOP;
                    rtap_srams_bist_data    <= '0;
                end
            endcase
`ifdef BIST_INITIATOR_ABORT_EN
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram_bist_initiator.sv
// tb_sram_bist_initiator
// Two initiators (return latency 0 and 3) each drive a behavioural sp_ram
// BIST slave (SR_ID 0x25, chunk 0, 64-bit words). Directed transactions with
// hand-computed expected bus sequences, response timing and data.
module tb_sram_bist_initiator;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_ID   = 3'd1;
    localparam logic [2:0] C_BSEL = 3'd2;
    localparam logic [2:0] C_ADDR = 3'd3;
    localparam logic [2:0] C_READ = 3'd4;
    localparam logic [2:0] C_DATA = 3'd5;
    localparam logic [7:0] MY_ID  = 8'h25;

    logic         clk;
    logic         rst;
    logic         rv   [2];
    logic         rw   [2];
    logic [7:0]   rid  [2];
    logic [7:0]   rch  [2];
    logic [15:0]  radr [2];
    logic [319:0] rwd  [2];
    logic         rdy  [2];
    logic         rspv [2];
    logic         rspw [2];
    logic [383:0] rdat [2];
    logic         bsy  [2];
    logic [2:0]   cmd_a [2];
    logic [3:0]   dat_a [2];
    logic [3:0]   rtn_a [2];
`ifdef BIST_INITIATOR_ABORT_EN
    logic         ab   [2];
    logic         abo  [2];
`endif

    // Slave model state
    logic [7:0]   s_id    [2];
    logic [7:0]   s_bsel  [2];
    logic [15:0]  s_addr  [2];
    logic [63:0]  s_wsh   [2];
    logic [383:0] s_out   [2];
    logic [6:0]   s_beats [2];
    logic         s_rd    [2];
    logic [2:0]   s_prev  [2];
    logic [63:0]  mem [2][65536];
    logic [3:0]   d1, d2, d3;

    logic         pl_en;
    int           pl_i;
    logic [15:0]  pl_addr;
    logic [63:0]  pl_data;

    int checks;
    int errors;
    int vcyc, rcyc, vcount;
    logic [2:0] lcmd [13];
    logic [3:0] ldat [13];

    sram_bist_initiator #(.RSP_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]),
        .req_sram_id(rid[0]), .req_chunk_id(rch[0]), .req_addr(radr[0]),
        .req_wdata(rwd[0]),
        .rsp_valid(rspv[0]), .rsp_write(rspw[0]), .rsp_rdata(rdat[0]),
        .busy(bsy[0]),
        .rtap_srams_bist_command(cmd_a[0]), .rtap_srams_bist_data(dat_a[0]),
        .srams_rtap_data(rtn_a[0])
`ifdef BIST_INITIATOR_ABORT_EN
        , .abort(ab[0]), .rsp_aborted(abo[0])
`endif
    );

    sram_bist_initiator #(.RSP_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]),
        .req_sram_id(rid[1]), .req_chunk_id(rch[1]), .req_addr(radr[1]),
        .req_wdata(rwd[1]),
        .rsp_valid(rspv[1]), .rsp_write(rspw[1]), .rsp_rdata(rdat[1]),
        .busy(bsy[1]),
        .rtap_srams_bist_command(cmd_a[1]), .rtap_srams_bist_data(dat_a[1]),
        .srams_rtap_data(rtn_a[1])
`ifdef BIST_INITIATOR_ABORT_EN
        , .abort(ab[1]), .rsp_aborted(abo[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave 0 returns combinationally; slave 1 goes through a 3-stage delay.
    assign rtn_a[0] = s_out[0][383:380];
    assign rtn_a[1] = d3;

    always_ff @(posedge clk) begin
        d1 <= s_out[1][383:380];
        d2 <= d1;
        d3 <= d2;
    end

    // Behavioural sp_ram BIST slave, one per initiator.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            s_prev[i] <= cmd_a[i];
            case (cmd_a[i])
                C_ID: begin
                    s_id[i]    <= {s_id[i][3:0], dat_a[i]};
                    s_beats[i] <= '0;
                    s_rd[i]    <= 1'b0;
                end
                C_BSEL: s_bsel[i] <= {s_bsel[i][3:0], dat_a[i]};
                C_ADDR: s_addr[i] <= {s_addr[i][11:0], dat_a[i]};
                C_READ: begin
                    s_rd[i] <= 1'b1;
                    if (s_id[i] == MY_ID && s_bsel[i] == 8'h00)
                        s_out[i] <= {320'h0, mem[i][s_addr[i]]};
                    else
                        s_out[i] <= '0;
                end
                C_DATA: begin
                    if (s_rd[i]) begin
                        s_out[i] <= {s_out[i][379:0], 4'h0};
                    end else begin
                        s_wsh[i]   <= {s_wsh[i][59:0], dat_a[i]};
                        s_beats[i] <= s_beats[i] + 7'd1;
                    end
                end
                C_NOP: begin
                    if (s_prev[i] == C_DATA) begin
                        if (!s_rd[i] && s_id[i] == MY_ID && s_bsel[i] == 8'h00 &&
                            s_beats[i] == 7'd80)
                            mem[i][s_addr[i]] <= s_wsh[i];
                        s_out[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
        if (pl_en) mem[pl_i][pl_addr] <= pl_data;
    end

    task automatic preload(input int i, input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_i = i; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
        @(negedge clk);
    endtask

    // Must be called at a falling edge with the initiator idle; the next
    // rising edge is the acceptance edge T0. Returns when req_ready rises.
    task automatic run_txn(input int i, input logic w, input logic [7:0] id,
                           input logic [7:0] ch, input logic [15:0] ad,
                           input logic [319:0] wd);
        rv[i] = 1'b1; rw[i] = w; rid[i] = id; rch[i] = ch; radr[i] = ad; rwd[i] = wd;
        @(posedge clk);
        #1 rv[i] = 1'b0;
        vcyc = -1; rcyc = -1; vcount = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n <= 12) begin
                lcmd[n] = cmd_a[i];
                ldat[n] = dat_a[i];
            end
            if (rspv[i]) begin
                if (vcyc < 0) vcyc = n;
                vcount++;
            end
            if (rdy[i] && rcyc < 0) rcyc = n;
            if (rcyc >= 0) break;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++; if (cmd_a[i] !== C_NOP) begin errors++; $display("FAIL reset_cmd[%0d] got %0d want 0", i, cmd_a[i]); end
            checks++; if (dat_a[i] !== 4'h0) begin errors++; $display("FAIL reset_dat[%0d] got %0h want 0", i, dat_a[i]); end
            checks++; if (rspv[i] !== 1'b0) begin errors++; $display("FAIL reset_rspv[%0d] got %b want 0", i, rspv[i]); end
            checks++; if (rspw[i] !== 1'b0) begin errors++; $display("FAIL reset_rspw[%0d] got %b want 0", i, rspw[i]); end
            checks++; if (rdat[i] !== 384'h0) begin errors++; $display("FAIL reset_rdata[%0d] got %0h want 0", i, rdat[i]); end
            checks++; if (rdy[i] !== 1'b1 || bsy[i] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d] got rdy=%b busy=%b want 1/0", i, rdy[i], bsy[i]); end
`ifdef BIST_INITIATOR_ABORT_EN
            checks++; if (abo[i] !== 1'b0) begin errors++; $display("FAIL reset_aborted[%0d] got %b want 0", i, abo[i]); end
`endif
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_basic;
        logic [2:0] ec [13];
        logic [3:0] ed [13];
        ec = '{C_NOP, C_ID, C_ID, C_BSEL, C_BSEL, C_ADDR, C_ADDR, C_ADDR, C_ADDR,
               C_READ, C_NOP, C_DATA, C_DATA};
        ed = '{4'h0, 4'h2, 4'h5, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3,
               4'h0, 4'h0, 4'h0, 4'h0};
        preload(0, 16'h0123, 64'hDEADBEEF_CAFEF00D);
        run_txn(0, 1'b0, 8'h25, 8'h00, 16'h0123, 320'h0);
        for (int n = 1; n <= 12; n++) begin
            checks++;
            if (lcmd[n] !== ec[n] || ldat[n] !== ed[n]) begin
                errors++;
                $display("FAIL rd_bus T%0d got cmd=%0d nib=%0h want cmd=%0d nib=%0h", n, lcmd[n], ldat[n], ec[n], ed[n]);
            end
        end
        checks++; if (vcyc != 107) begin errors++; $display("FAIL rd_valid_cycle got %0d want 107", vcyc); end
        checks++; if (vcount != 1) begin errors++; $display("FAIL rd_valid_pulses got %0d want 1", vcount); end
        checks++; if (rcyc != 109) begin errors++; $display("FAIL rd_ready_cycle got %0d want 109", rcyc); end
        checks++; if (rdat[0] !== {320'h0, 64'hDEADBEEF_CAFEF00D}) begin errors++; $display("FAIL rd_data got %0h want deadbeefcafef00d", rdat[0]); end
        checks++; if (rspw[0] !== 1'b0) begin errors++; $display("FAIL rd_rsp_write got %b want 0", rspw[0]); end
    endtask

    task automatic test_write_back_to_back;
        logic [319:0] wd;
        wd = {8'hA5, 248'h0, 64'h1234_5678_9ABC_DEF0};
        run_txn(0, 1'b1, 8'h25, 8'h00, 16'h0040, wd);
        checks++; if (lcmd[9] !== C_DATA || ldat[9] !== 4'hA) begin errors++; $display("FAIL wr_beat0 got cmd=%0d nib=%0h want 5/a", lcmd[9], ldat[9]); end
        checks++; if (lcmd[10] !== C_DATA || ldat[10] !== 4'h5) begin errors++; $display("FAIL wr_beat1 got cmd=%0d nib=%0h want 5/5", lcmd[10], ldat[10]); end
        checks++; if (vcyc != 89) begin errors++; $display("FAIL wr_valid_cycle got %0d want 89", vcyc); end
        checks++; if (rcyc != 91) begin errors++; $display("FAIL wr_ready_cycle got %0d want 91", rcyc); end
        checks++; if (rspw[0] !== 1'b1) begin errors++; $display("FAIL wr_rsp_write got %b want 1", rspw[0]); end
        checks++; if (mem[0][16'h0040] !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL wr_mem got %0h want 123456789abcdef0", mem[0][16'h0040]); end
        // Issued in the cycle req_ready rose.
        run_txn(0, 1'b0, 8'h25, 8'h00, 16'h0040, 320'h0);
        checks++; if (lcmd[1] !== C_ID || ldat[1] !== 4'h2) begin errors++; $display("FAIL b2b_first_shift got cmd=%0d nib=%0h want 1/2", lcmd[1], ldat[1]); end
        checks++; if (vcyc != 107) begin errors++; $display("FAIL b2b_valid_cycle got %0d want 107", vcyc); end
        checks++; if (rdat[0] !== {320'h0, 64'h1234_5678_9ABC_DEF0}) begin errors++; $display("FAIL b2b_readback got %0h want 123456789abcdef0", rdat[0]); end
    endtask

    task automatic test_nonmatch;
        @(negedge clk);
        run_txn(0, 1'b0, 8'h26, 8'h00, 16'h0123, 320'h0);
        checks++; if (lcmd[1] !== C_ID || ldat[1] !== 4'h2 || ldat[2] !== 4'h6) begin errors++; $display("FAIL nm_id got cmd=%0d nibs=%0h%0h want 1/26", lcmd[1], ldat[1], ldat[2]); end
        checks++; if (vcyc != 107) begin errors++; $display("FAIL nm_valid_cycle got %0d want 107", vcyc); end
        checks++; if (rdat[0] !== 384'h0) begin errors++; $display("FAIL nm_data got %0h want 0", rdat[0]); end
    endtask

    task automatic test_latency3;
        preload(1, 16'h0123, 64'hDEADBEEF_CAFEF00D);
        run_txn(1, 1'b0, 8'h25, 8'h00, 16'h0123, 320'h0);
        checks++; if (lcmd[9] !== C_READ || lcmd[11] !== C_DATA) begin errors++; $display("FAIL l3_bus got T9=%0d T11=%0d want 4/5", lcmd[9], lcmd[11]); end
        checks++; if (vcyc != 110) begin errors++; $display("FAIL l3_valid_cycle got %0d want 110", vcyc); end
        checks++; if (rcyc != 112) begin errors++; $display("FAIL l3_ready_cycle got %0d want 112", rcyc); end
        checks++; if (rdat[1] !== {320'h0, 64'hDEADBEEF_CAFEF00D}) begin errors++; $display("FAIL l3_data got %0h want deadbeefcafef00d", rdat[1]); end
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; rid[0] = 8'h25; rch[0] = 8'h00; radr[0] = 16'h0040;
        rwd[0] = {256'h0, 64'hFFFF_EEEE_DDDD_CCCC};
        @(posedge clk);
        #1 rv[0] = 1'b0;
        for (int n = 1; n <= 40; n++) @(negedge clk);
        checks++; if (cmd_a[0] !== C_DATA) begin errors++; $display("FAIL mid_pre_cmd got %0d want 5", cmd_a[0]); end
        rst = 1'b1;
        #1;
        checks++; if (cmd_a[0] !== C_NOP || dat_a[0] !== 4'h0) begin errors++; $display("FAIL mid_rst_bus got cmd=%0d nib=%0h want 0/0", cmd_a[0], dat_a[0]); end
        checks++; if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || rspv[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got rdy=%b busy=%b vld=%b want 1/0/0", rdy[0], bsy[0], rspv[0]); end
        checks++; if (rdat[0] !== 384'h0) begin errors++; $display("FAIL mid_rst_rdata got %0h want 0", rdat[0]); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem[0][16'h0040] !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL mid_mem got %0h want 123456789abcdef0", mem[0][16'h0040]); end
        run_txn(0, 1'b0, 8'h25, 8'h00, 16'h0040, 320'h0);
        checks++; if (vcyc != 107) begin errors++; $display("FAIL post_rst_valid got %0d want 107", vcyc); end
        checks++; if (rdat[0] !== {320'h0, 64'h1234_5678_9ABC_DEF0}) begin errors++; $display("FAIL post_rst_data got %0h want 123456789abcdef0", rdat[0]); end
    endtask

`ifdef BIST_INITIATOR_ABORT_EN
    task automatic test_abort;
        int got;
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; rid[0] = 8'h25; rch[0] = 8'h00; radr[0] = 16'h0040;
        rwd[0] = {256'h0, 64'h0BAD_0BAD_0BAD_0BAD};
        @(posedge clk);
        #1 rv[0] = 1'b0;
        for (int n = 1; n <= 50; n++) @(negedge clk);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        checks++; if (cmd_a[0] !== C_NOP) begin errors++; $display("FAIL ab_cmd T51 got %0d want 0", cmd_a[0]); end
        checks++; if (rspv[0] !== 1'b1 || abo[0] !== 1'b1) begin errors++; $display("FAIL ab_rsp T51 got vld=%b aborted=%b want 1/1", rspv[0], abo[0]); end
        checks++; if (rdat[0] !== {320'h0, 64'h1234_5678_9ABC_DEF0}) begin errors++; $display("FAIL ab_rdata got %0h want unchanged", rdat[0]); end
        got = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rdy[0]) begin got = 1; break; end
        end
        checks++; if (got != 1) begin errors++; $display("FAIL ab_ready got %0d want 1", got); end
        checks++; if (mem[0][16'h0040] !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL ab_mem got %0h want 123456789abcdef0", mem[0][16'h0040]); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; pl_en = 1'b0; pl_i = 0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; rid[i] = '0; rch[i] = '0; radr[i] = '0; rwd[i] = '0;
`ifdef BIST_INITIATOR_ABORT_EN
            ab[i] = 1'b0;
`endif
        end
        test_reset;
        test_read_basic;
        test_write_back_to_back;
        test_nonmatch;
        test_latency3;
        test_reset_mid_write;
`ifdef BIST_INITIATOR_ABORT_EN
        test_abort;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
